// File: rtl/ttl74x597_if.sv
// Bus bundle for the ttl74x597 shift register: parallel/serial data and strobes.
// The driver of D/RCK/SLOAD_n/SCK/SER uses master; the register uses slave.
interface ttl74x597_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             RCK;
    logic             SLOAD_n;
    logic             SCK;
    logic             SER;
    logic             QH;
    logic             DONE;

    modport master (
        output D, RCK, SLOAD_n, SCK, SER,
        input  QH, DONE
    );

    modport slave (
        input  D, RCK, SLOAD_n, SCK, SER,
        output QH, DONE
    );
endinterface

// File: rtl/ttl74x597.sv
// SN74LS597-style storage + shift register on a single clock, serialising MSB-first on QH.
// Optional macro TTL74X597_DONE_EN builds a bit counter driving DONE; otherwise DONE is 0.
module ttl74x597 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         MR_n,
    ttl74x597_if.slave   bus
);
    logic [WIDTH-1:0] storage_q, storage_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             load, shift_en;

    assign load     = ~bus.SLOAD_n;
    assign shift_en = bus.SLOAD_n & bus.SCK;

    // Shift register loads from the pre-edge storage value, so a same-edge capture is not bypassed.
    always_comb begin
        storage_d = storage_q;
        shift_d   = shift_q;
        if (bus.RCK)
            storage_d = bus.D;
        if (load)
            shift_d = storage_q;
        else if (shift_en)
            shift_d = {shift_q[WIDTH-2:0], bus.SER};
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            storage_q <= '0;
            shift_q   <= '0;
        end else begin
            storage_q <= storage_d;
            shift_q   <= shift_d;
        end
    end

    assign bus.QH = shift_q[WIDTH-1];

`ifdef TTL74X597_DONE_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (shift_en && (cnt_q < CW'(WIDTH)))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.DONE = (cnt_q == CW'(WIDTH));
`else
    assign bus.DONE = 1'b0;
`endif
endmodule

// File: tb/tb_ttl74x597.sv
// Self-checking bench for ttl74x597: directed scenarios then random traffic against a
// behavioural model (storage value, shift value as an integer, shifts-since-load count).
module tb_ttl74x597;
    localparam int W = 8;

    logic clk = 1'b0;
    logic MR_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    ttl74x597_if #(.WIDTH(W)) bus ();

    ttl74x597 #(.WIDTH(W)) dut (
        .clk  (clk),
        .MR_n (MR_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_store;
    int unsigned m_shift;
    int          m_shifts;   // shifts since last load, saturating at W

    function automatic logic exp_qh();
        return logic'((m_shift >> (W - 1)) & 1);
    endfunction

    function automatic logic exp_done();
`ifdef TTL74X597_DONE_EN
        return logic'(m_shifts == W);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_store  = 0;
        m_shift  = 0;
        m_shifts = 0;
    endtask

    // Apply one clock of inputs, advance the model, check outputs #1 after the edge.
    task automatic step(input string tag, input int unsigned d, input logic rck,
                        input logic sload_n, input logic sck, input logic ser);
        int unsigned mask;
        mask        = (1 << W) - 1;
        bus.D       = d[W-1:0];
        bus.RCK     = rck;
        bus.SLOAD_n = sload_n;
        bus.SCK     = sck;
        bus.SER     = ser;
        @(posedge clk);
        #1;
        if (!sload_n) begin
            m_shift  = m_store;
            m_shifts = 0;
        end else if (sck) begin
            m_shift  = ((m_shift << 1) | int'(ser)) & mask;
            if (m_shifts < W) m_shifts++;
        end
        if (rck) m_store = d & mask;
        chk({tag, ".QH"}, bus.QH, exp_qh());
        chk({tag, ".DONE"}, bus.DONE, exp_done());
    endtask

    initial begin
        logic qh_hold;
        logic [7:0] pat;
        model_reset();
        bus.D = '0; bus.RCK = 1'b0; bus.SLOAD_n = 1'b1; bus.SCK = 1'b0; bus.SER = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.QH", bus.QH, 1'b0);
        chk("rst.DONE", bus.DONE, 1'b0);
        @(negedge clk);
        MR_n = 1'b1;
        @(posedge clk); #1;

        // Basic serialise of 0xA5, also checked against the literal bit pattern
        step("cap_a5", 32'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ld_a5", 32'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ld_a5.lit", bus.QH, 1'b1);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step("sh_a5", $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("sh_a5.lit", bus.QH, (i < 7) ? pat[6-i] : 1'b0);
        end

        // Capture/load collision: load sees old 0xA5, later load sees 0x3C
        step("coll", 32'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("coll.lit", bus.QH, 1'b1);
        for (int i = 0; i < W; i++)
            step("coll_sh", $urandom, 1'b0, 1'b1, 1'b1, $urandom_range(1));
        step("ld_3c", $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ld_3c.lit", bus.QH, 1'b0);

        // DONE: 10 shifts after load, then a reload
        for (int i = 1; i <= 10; i++) begin
            step("done_sh", $urandom, 1'b0, 1'b1, 1'b1, $urandom_range(1));
`ifdef TTL74X597_DONE_EN
            chk("done.lit", bus.DONE, (i >= W) ? 1'b1 : 1'b0);
`else
            chk("done.lit", bus.DONE, 1'b0);
`endif
        end
        step("done_ld", $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_ld.lit", bus.DONE, 1'b0);

        // Load beats shift
        step("cap_81", 32'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ld_vs_sh", $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ld_vs_sh.lit", bus.QH, 1'b1);
        step("ld_vs_sh1", $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ld_vs_sh1.lit", bus.QH, 1'b0);

        // Hold: D toggles, nothing enabled
        qh_hold = bus.QH;
        for (int i = 0; i < 20; i++) begin
            step("hold", $urandom, 1'b0, 1'b1, 1'b0, $urandom_range(1));
            chk("hold.stable", bus.QH, qh_hold);
        end
        step("hold_ld", $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++)
            step("hold_sh", $urandom, 1'b0, 1'b1, 1'b1, 1'b0);

        // Async reset mid-cycle after loading 0xFF
        step("cap_ff", 32'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ld_ff", $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++)
            step("ff_sh", $urandom, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 MR_n = 1'b0;
        model_reset();
        #1;
        chk("arst.QH", bus.QH, 1'b0);
        chk("arst.DONE", bus.DONE, 1'b0);
        #1 MR_n = 1'b1;
        step("arst_ld", $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++)
            step("arst_sh", $urandom, 1'b0, 1'b1, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step("rand", $urandom, logic'($urandom_range(3) == 0),
                 logic'($urandom_range(5) != 0), logic'($urandom_range(3) != 0),
                 logic'($urandom_range(1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ttl74x597.md
# ttl74x597

Parameterised RTL model of an SN74LS597-style shift register with an input storage register, adapted to a single clock. It sits directly downstream of the 74x163 counters. The counter outputs Q (two cascaded 4-bit stages give 8 bits) drive D, and the design strobes RCK to snapshot the count. The captured value is then serialised MSB-first on QH for a single-wire consumer.

## Interface
Parameters:
- WIDTH, default 8: width of the storage and shift registers (minimum 2).

Ports:
- clk  input  1  rising-edge clock; every register updates on this edge only.
- MR_n  input  1  asynchronous active-low master reset; clears storage register, shift register and bit counter.
- D  input  WIDTH  parallel data into the storage register (typically counter Q).
- RCK  input  1  storage capture enable; when high, storage <= D on the rising clk edge.
- SLOAD_n  input  1  active-low synchronous load of the shift register from the storage register.
- SCK  input  1  shift enable, active high.
- SER  input  1  serial data into bit 0.
- QH  output  1  serial out, equal to shift[WIDTH-1].
- DONE  output  1  WIDTH bits shifted since the last load (see Configuration).

## Operation
- Storage register: storage <= D when RCK is high, otherwise it holds. It is independent of SLOAD_n and SCK.
- Shift register priority, highest first:
  - SLOAD_n = 0: shift <= storage.
  - Otherwise, SCK = 1: shift <= {shift[WIDTH-2:0], SER}.
  - Otherwise: hold.
- Simultaneous RCK = 1 and SLOAD_n = 0: the shift register receives the OLD storage value. The new D is visible only at the next load. There is no D-to-shift bypass.
- Simultaneous SLOAD_n = 0 and SCK = 1: the load wins and no shift occurs on that edge.
- Continued shifting after WIDTH shifts keeps inserting SER. There is no stop and no wrap.
- Bit counter (only when the macro is defined):
  - Width is $clog2(WIDTH+1).
  - It is cleared to 0 on a load.
  - It increments on each shift while below WIDTH, then saturates at WIDTH.
  - DONE = (cnt == WIDTH).
- Reset:
  - MR_n low immediately clears storage, shift and cnt to 0, so QH = 0 and DONE = 0 with no clk edge required.
  - It holds them cleared while low, and any in-progress serialisation is lost.
  - On the first rising edge after MR_n deasserts, normal priority applies.

## Timing
- QH and DONE are registered-state outputs with no combinational path from inputs.
- D-to-QH latency:
  - RCK at edge N captures D.
  - SLOAD_n low at edge N+1 or later loads the shift register.
  - QH shows bit WIDTH-1 after that edge.
  - Each subsequent SCK edge presents the next lower bit.
- DONE rises on the edge of the WIDTH-th shift after a load. It falls on the edge of the next load, or on reset.

## Configuration
- Macro TTL74X597_DONE_EN:
  - Defined: the bit counter is built and DONE behaves as in Operation.
  - Undefined: no counter logic is built and DONE is tied to 0. The port list is identical in both builds.

## Test plan
- Async reset: load 0xFF, then pulse MR_n low between clk edges -> QH = 0 and DONE = 0 before the next edge; storage reads 0 at the next load.
- Basic serialise (WIDTH = 8):
  - Stimulus: RCK = 1 with D = 0xA5; next edge SLOAD_n = 0; then 8 edges with SCK = 1 and SER = 0.
  - Required: QH = 1 after the load, then 0,1,0,0,1,0,1 on the first 7 shift edges, then 0 after the 8th.
- Capture/load collision: storage = 0xA5; same edge RCK = 1 with D = 0x3C and SLOAD_n = 0 -> shift = 0xA5; a later load gives shift = 0x3C.
- Load beats shift: SLOAD_n = 0 and SCK = 1 on the same edge with storage = 0x81 -> shift = 0x81, with no shift applied.
- DONE, macro defined:
  - Stimulus: load, then 10 shifts, then a new load.
  - Required: DONE = 0 for shifts 1–7, DONE = 1 from the 8th shift through the 10th, DONE = 0 after the new load.
  - With the macro undefined, DONE = 0 throughout.
- Hold: RCK = 0, SCK = 0, SLOAD_n = 1 for 20 cycles while D toggles randomly -> shift register and storage unchanged, QH stable.
